// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide unit.
// Optional MADD support is selected by the MD_UNIT_MADD_EN macro in md_unit_ctrl.
package md_pkg;

    localparam int DATA_W         = 32;
    localparam int MD_MUL_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF = 10;
    localparam int MD_CNT_W       = 4;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and md_unit_ctrl.
interface md_unit_ctrl_if;

    logic        start_ex;
    logic [2:0]  op_ex;
    logic [31:0] src_a_ex;
    logic [31:0] src_b_ex;
    logic        mthi_ex;
    logic        mtlo_ex;
    logic        md_use_id;
    logic        flush_ex;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start_ex, op_ex, src_a_ex, src_b_ex, mthi_ex, mtlo_ex, md_use_id, flush_ex,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start_ex, op_ex, src_a_ex, src_b_ex, mthi_ex, mtlo_ex, md_use_id, flush_ex,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// Combinational {hi,lo} result generator for MULT/MULTU/DIV/DIVU/MADD.
// MADD is always computed here; whether it is accepted depends on MD_UNIT_MADD_EN in the top.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic [63:0] res
);

    logic signed [63:0] a_sx, b_sx, prod_s, acc_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s, b_s, q_s, r_s;
    logic        [31:0] q_u, r_u, b_safe;
    logic               div_zero, div_ovf;

    always_comb begin
        a_s      = signed'(a);
        a_sx     = {{32{a[31]}}, a};
        b_sx     = {{32{b[31]}}, b};
        prod_s   = a_sx * b_sx;
        prod_u   = {32'd0, a} * {32'd0, b};
        acc_s    = signed'({hi_cur, lo_cur}) + prod_s;

        div_zero = (b == 32'd0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        // Keep the divider inputs well-defined; the two corner cases are patched below.
        b_safe   = (div_zero || div_ovf) ? 32'd1 : b;
        b_s      = signed'(b_safe);
        q_s      = a_s / b_s;
        r_s      = a_s % b_s;
        q_u      = a / b_safe;
        r_u      = a % b_safe;

        res = '0;
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV: begin
                if (div_zero)     res = {a, 32'hFFFF_FFFF};
                else if (div_ovf) res = {32'd0, 32'h8000_0000};
                else              res = {r_s, q_s};
            end
            MD_DIVU: begin
                if (div_zero) res = {a, 32'hFFFF_FFFF};
                else          res = {r_u, q_u};
            end
            MD_MADD:  res = acc_s;
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide scheduler owning HI/LO; results commit after a fixed latency.
// Define MD_UNIT_MADD_EN to accept op 4 (signed multiply-accumulate into {hi,lo}).
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT_DEF,
    parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    md_unit_ctrl_if.slave  md
);

    md_state_e             state;
    logic [MD_CNT_W-1:0]   cnt;
    logic                  busy_q;
    logic [31:0]           hi_q, lo_q, pend_hi, pend_lo;
    logic [63:0]           res;
    logic                  op_ok;
    logic                  start_ok;

`ifdef MD_UNIT_MADD_EN
    assign op_ok = (md.op_ex <= 3'd4);
`else
    assign op_ok = (md.op_ex <= 3'd3);
`endif

    assign start_ok = md.start_ex && !md.flush_ex && op_ok;

    md_arith u_arith (
        .op     (md.op_ex),
        .a      (md.src_a_ex),
        .b      (md.src_b_ex),
        .hi_cur (hi_q),
        .lo_cur (lo_q),
        .res    (res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start_ok) begin
                        state              <= MD_RUN;
                        busy_q             <= 1'b1;
                        {pend_hi, pend_lo} <= res;
                        cnt <= md_is_div(md.op_ex) ? MD_CNT_W'(DIV_LAT - 1)
                                                   : MD_CNT_W'(MUL_LAT - 1);
                    end else if (!md.start_ex && !md.flush_ex) begin
                        // Any start_ex, even an invalid op, takes precedence over a move.
                        if (md.mthi_ex) hi_q <= md.src_a_ex;
                        if (md.mtlo_ex) lo_q <= md.src_a_ex;
                    end
                end
                MD_RUN: begin
                    if (cnt == '0) begin
                        hi_q   <= pend_hi;
                        lo_q   <= pend_lo;
                        busy_q <= 1'b0;
                        state  <= MD_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign md.busy     = busy_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.stall_md = md.md_use_id && (busy_q || (md.start_ex && !md.flush_ex));

    // The hazard stall should make a start during an in-flight op impossible.
    start_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(busy_q && md.start_ex && !md.flush_ex));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: table of arithmetic vectors plus hand-written corner sequences.
module tb_md_unit_ctrl;
    import md_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    md_unit_ctrl_if bus ();

    md_unit_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start_ex  = 1'b0;
        bus.op_ex     = 3'd0;
        bus.src_a_ex  = 32'd0;
        bus.src_b_ex  = 32'd0;
        bus.mthi_ex   = 1'b0;
        bus.mtlo_ex   = 1'b0;
        bus.md_use_id = 1'b0;
        bus.flush_ex  = 1'b0;
    endtask

    // Accept an op at edge N, check hold values through N+LAT-1 and the commit at N+LAT.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        int lat;
        lat = (op == MD_DIV || op == MD_DIVU) ? DIV_LAT : MUL_LAT;
        @(negedge clk);
        old_hi = bus.hi;
        old_lo = bus.lo;
        bus.start_ex = 1'b1;
        bus.op_ex    = op;
        bus.src_a_ex = a;
        bus.src_b_ex = b;
        @(posedge clk); #1;
        bus.start_ex = 1'b0;
        chk({name, " busy_accept"}, {31'd0, bus.busy}, 32'd1);
        repeat (lat - 1) begin
            @(posedge clk); #1;
        end
        chk({name, " busy_last"}, {31'd0, bus.busy}, 32'd1);
        chk({name, " hold_hi"}, bus.hi, old_hi);
        chk({name, " hold_lo"}, bus.lo, old_lo);
        @(posedge clk); #1;
        chk({name, " busy_done"}, {31'd0, bus.busy}, 32'd0);
        chk({name, " hi"}, bus.hi, exp_hi);
        chk({name, " lo"}, bus.lo, exp_lo);
    endtask

    task automatic move(input logic h, input logic l, input logic [31:0] v, input logic fl);
        @(negedge clk);
        bus.mthi_ex  = h;
        bus.mtlo_ex  = l;
        bus.src_a_ex = v;
        bus.flush_ex = fl;
        @(posedge clk); #1;
        bus.mthi_ex  = 1'b0;
        bus.mtlo_ex  = 1'b0;
        bus.flush_ex = 1'b0;
    endtask

    initial begin
        logic [31:0] h0, l0;

        vecs[0]  = '{"mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{"multu_big", MD_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2]  = '{"mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{"multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4]  = '{"divu",      MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5]  = '{"div_neg_a", MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{"div_neg_b", MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{"div_zero",  MD_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[8]  = '{"divu_zero", MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[9]  = '{"div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[10] = '{"divu_16",   MD_DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset busy",  {31'd0, bus.busy},     32'd0);
        chk("reset stall", {31'd0, bus.stall_md}, 32'd0);
        chk("reset hi",    bus.hi, 32'd0);
        chk("reset lo",    bus.lo, 32'd0);

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

        // Stall: asserted with the start, through every busy cycle, dropped after commit.
        @(negedge clk);
        bus.md_use_id = 1'b1;
        bus.start_ex  = 1'b1;
        bus.op_ex     = MD_MULT;
        bus.src_a_ex  = 32'd2;
        bus.src_b_ex  = 32'd3;
        #1 chk("stall start", {31'd0, bus.stall_md}, 32'd1);
        @(posedge clk); #1;
        bus.start_ex = 1'b0;
        chk("stall busy0", {31'd0, bus.stall_md}, 32'd1);
        for (int k = 1; k < MUL_LAT; k++) begin
            @(posedge clk); #1;
            chk("stall busyN", {31'd0, bus.stall_md}, 32'd1);
        end
        @(posedge clk); #1;
        chk("stall after", {31'd0, bus.stall_md}, 32'd0);
        chk("stall lo", bus.lo, 32'd6);
        bus.md_use_id = 1'b0;

        // Moves, including a flushed move and a move that loses to a start.
        move(1'b1, 1'b0, 32'h0000_1234, 1'b0);
        chk("mthi hi", bus.hi, 32'h0000_1234);
        chk("mthi lo", bus.lo, 32'd6);
        move(1'b0, 1'b1, 32'h0000_5678, 1'b0);
        chk("mtlo lo", bus.lo, 32'h0000_5678);
        move(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("flush mv hi", bus.hi, 32'h0000_1234);
        chk("flush mv lo", bus.lo, 32'h0000_5678);

        @(negedge clk);
        bus.start_ex = 1'b1;
        bus.mthi_ex  = 1'b1;
        bus.op_ex    = MD_MULTU;
        bus.src_a_ex = 32'd9;
        bus.src_b_ex = 32'd4;
        @(posedge clk); #1;
        bus.start_ex = 1'b0;
        bus.mthi_ex  = 1'b0;
        chk("start+mthi hi", bus.hi, 32'h0000_1234);
        repeat (MUL_LAT) @(posedge clk);
        #1;
        chk("start+mthi res hi", bus.hi, 32'd0);
        chk("start+mthi res lo", bus.lo, 32'd36);

        // Flushed start is never accepted.
        @(negedge clk);
        bus.start_ex = 1'b1;
        bus.flush_ex = 1'b1;
        bus.op_ex    = MD_MULT;
        bus.src_a_ex = 32'd3;
        bus.src_b_ex = 32'd3;
        @(posedge clk); #1;
        bus.start_ex = 1'b0;
        bus.flush_ex = 1'b0;
        chk("flush start busy", {31'd0, bus.busy}, 32'd0);
        repeat (MUL_LAT) @(posedge clk);
        #1;
        chk("flush start lo", bus.lo, 32'd36);

        // Flush arriving after acceptance does not cancel the op.
        @(negedge clk);
        bus.start_ex = 1'b1;
        bus.op_ex    = MD_MULTU;
        bus.src_a_ex = 32'd3;
        bus.src_b_ex = 32'd4;
        @(posedge clk); #1;
        bus.start_ex = 1'b0;
        bus.flush_ex = 1'b1;
        @(posedge clk); #1;
        bus.flush_ex = 1'b0;
        chk("late flush busy", {31'd0, bus.busy}, 32'd1);
        repeat (MUL_LAT - 1) @(posedge clk);
        #1;
        chk("late flush lo", bus.lo, 32'd12);

        // Invalid opcodes are no-ops.
        for (int op = 5; op < 8; op++) begin
            @(negedge clk);
            bus.start_ex = 1'b1;
            bus.op_ex    = 3'(op);
            @(posedge clk); #1;
            bus.start_ex = 1'b0;
            chk("invalid op busy", {31'd0, bus.busy}, 32'd0);
        end
        chk("invalid op lo", bus.lo, 32'd12);

        // Reset during RUN cycle 3 discards the pending result.
        @(negedge clk);
        bus.start_ex = 1'b1;
        bus.op_ex    = MD_DIVU;
        bus.src_a_ex = 32'd100;
        bus.src_b_ex = 32'd7;
        @(posedge clk); #1;
        bus.start_ex = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset hi", bus.hi, 32'd0);
        chk("midreset lo", bus.lo, 32'd0);
        repeat (DIV_LAT) @(posedge clk);
        #1;
        chk("midreset no commit", bus.lo, 32'd0);

`ifdef MD_UNIT_MADD_EN
        move(1'b1, 1'b0, 32'd0, 1'b0);
        move(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_op("madd", MD_MADD, 32'd1, 32'd1, 32'd1, 32'd0);
`else
        move(1'b1, 1'b1, 32'h0000_0077, 1'b0);
        h0 = bus.hi;
        l0 = bus.lo;
        @(negedge clk);
        bus.start_ex = 1'b1;
        bus.op_ex    = 3'd4;
        bus.src_a_ex = 32'd1;
        bus.src_b_ex = 32'd1;
        @(posedge clk); #1;
        bus.start_ex = 1'b0;
        chk("madd off busy", {31'd0, bus.busy}, 32'd0);
        repeat (MUL_LAT) @(posedge clk);
        #1;
        chk("madd off hi", bus.hi, 32'h0000_0077);
        chk("madd off lo", bus.lo, l0);
        chk("madd off hi0", h0, 32'h0000_0077);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
